// File: rtl/ff_ctrl.sv
// FIFO controller driving an external single-port RAM: push/pop handshake, pointers, occupancy.
// Optional round-robin push/pop arbitration when FF_CTRL_RR_ARB_EN is defined (default: pop wins).
module ff_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  push_ready,
   input  logic                  pop,
   output logic                  pop_ready,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  pop_valid,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  ram_cs,
   output logic                  ram_rws,
   output logic [ADDR_WIDTH-1:0] ram_wptr,
   output logic [ADDR_WIDTH-1:0] ram_rptr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out
);

   localparam int unsigned CW = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [CW-1:0]         r_count;
   logic                  r_ram_cs;
   logic                  r_ram_rws;
   logic [ADDR_WIDTH-1:0] r_ram_wptr;
   logic [ADDR_WIDTH-1:0] r_ram_rptr;
   logic [DATA_WIDTH-1:0] r_ram_data_in;
   logic [DATA_WIDTH-1:0] r_pop_data;
   logic                  r_pop_valid;

   logic                  w_idle;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push_ok;
   logic                  w_pop_ok;
   logic                  w_push_ready;
   logic                  w_pop_ready;
   logic                  w_push_acc;
   logic                  w_pop_acc;
   logic [ADDR_WIDTH-1:0] w_wptr_nxt;
   logic [ADDR_WIDTH-1:0] w_rptr_nxt;

   assign w_idle    = (r_state == ST_IDLE);
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == CW'(0));
   assign w_push_ok = w_idle && !w_full;
   assign w_pop_ok  = w_idle && !w_empty;

`ifdef FF_CTRL_RR_ARB_EN
   // r_last_pop: 1 = pop won the last contested cycle, so push wins the next one
   logic r_last_pop;

   assign w_push_ready = w_push_ok && !(pop && w_pop_ok && !r_last_pop);
   assign w_pop_ready  = w_pop_ok && !(push && w_push_ok && r_last_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_pop <= 1'b1;
      end else if (push && pop && w_push_ok && w_pop_ok) begin
         r_last_pop <= !r_last_pop;
      end
   end
`else
   assign w_push_ready = w_push_ok && !(pop && w_pop_ok);
   assign w_pop_ready  = w_pop_ok;
`endif

   assign w_push_acc = push && w_push_ready;
   assign w_pop_acc  = pop && w_pop_ready;

   // Pointer wrap is explicit so non-power-of-two DEPTH also works
   assign w_wptr_nxt = (r_wptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_wptr + ADDR_WIDTH'(1);
   assign w_rptr_nxt = (r_rptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_rptr + ADDR_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_count       <= '0;
         r_ram_cs      <= 1'b0;
         r_ram_rws     <= 1'b0;
         r_ram_wptr    <= '0;
         r_ram_rptr    <= '0;
         r_ram_data_in <= '0;
         r_pop_data    <= '0;
         r_pop_valid   <= 1'b0;
      end else begin
         r_pop_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_ram_cs  <= 1'b0;
               r_ram_rws <= 1'b0;
               if (w_pop_acc) begin
                  r_state    <= ST_READ;
                  r_ram_cs   <= 1'b1;
                  r_ram_rws  <= 1'b0;
                  r_ram_rptr <= r_rptr;
               end else if (w_push_acc) begin
                  r_state       <= ST_WRITE;
                  r_ram_cs      <= 1'b1;
                  r_ram_rws     <= 1'b1;
                  r_ram_wptr    <= r_wptr;
                  r_ram_data_in <= push_data;
               end
            end
            ST_WRITE: begin
               r_state   <= ST_IDLE;
               r_ram_cs  <= 1'b0;
               r_ram_rws <= 1'b0;
               r_wptr    <= w_wptr_nxt;
               r_count   <= r_count + CW'(1);
            end
            ST_READ: begin
               // RAM read word is valid during this cycle; capture it on the way out
               r_state     <= ST_IDLE;
               r_ram_cs    <= 1'b0;
               r_ram_rws   <= 1'b0;
               r_pop_data  <= ram_data_out;
               r_pop_valid <= 1'b1;
               r_rptr      <= w_rptr_nxt;
               r_count     <= r_count - CW'(1);
            end
            default: begin
               r_state   <= ST_IDLE;
               r_ram_cs  <= 1'b0;
               r_ram_rws <= 1'b0;
            end
         endcase
      end
   end

   assign push_ready  = w_push_ready;
   assign pop_ready   = w_pop_ready;
   assign pop_data    = r_pop_data;
   assign pop_valid   = r_pop_valid;
   assign full        = w_full;
   assign empty       = w_empty;
   assign count       = r_count;
   assign ram_cs      = r_ram_cs;
   assign ram_rws     = r_ram_rws;
   assign ram_wptr    = r_ram_wptr;
   assign ram_rptr    = r_ram_rptr;
   assign ram_data_in = r_ram_data_in;

endmodule

// File: tb/tb_ff_ctrl.sv
// Self-checking bench for ff_ctrl: per-cycle vector table plus directed multi-cycle sequences.
module tb_ff_ctrl;

`ifdef FF_CTRL_RR_ARB_EN
   localparam logic RR = 1'b1;
`else
   localparam logic RR = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       push;
   logic [7:0] push_data;
   logic       push_ready;
   logic       pop;
   logic       pop_ready;
   logic [7:0] pop_data;
   logic       pop_valid;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       ram_cs;
   logic       ram_rws;
   logic [2:0] ram_wptr;
   logic [2:0] ram_rptr;
   logic [7:0] ram_data_in;
   logic [7:0] ram_data_out;

   int total = 0;
   int bad   = 0;

   ff_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .DEPTH(8)) dut (
      .clk(clk), .rst(rst),
      .push(push), .push_data(push_data), .push_ready(push_ready),
      .pop(pop), .pop_ready(pop_ready), .pop_data(pop_data), .pop_valid(pop_valid),
      .full(full), .empty(empty), .count(count),
      .ram_cs(ram_cs), .ram_rws(ram_rws), .ram_wptr(ram_wptr), .ram_rptr(ram_rptr),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
   );

   // Behavioural RAM: synchronous write, asynchronous read
   logic [7:0] mem [0:7];
   always @(posedge clk) if (ram_cs && ram_rws) mem[ram_wptr] <= ram_data_in;
   assign ram_data_out = mem[ram_rptr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       push;
      logic       pop;
      logic [7:0] din;
      logic       pr;
      logic       qr;
      logic       cs;
      logic       rws;
      logic [3:0] cnt;
      logic       pv;
      logic [7:0] pd;
   } vec_t;

   function automatic vec_t mk(input logic p, input logic q, input logic [7:0] d,
                               input logic pr, input logic qr, input logic cs, input logic rws,
                               input logic [3:0] cnt, input logic pv, input logic [7:0] pd);
      vec_t v;
      v.push = p; v.pop = q; v.din = d; v.pr = pr; v.qr = qr;
      v.cs = cs; v.rws = rws; v.cnt = cnt; v.pv = pv; v.pd = pd;
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = 8'h00;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Push one word; returns while in the WRITE cycle
   task automatic push_word(input logic [7:0] d, input logic [2:0] exp_wptr);
      int n;
      @(negedge clk);
      push = 1'b1; push_data = d;
      #1;
      n = 0;
      while (!push_ready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      check($sformatf("push %0h accepted", d), 32'(n < 20), 32'd1);
      @(negedge clk);
      push = 1'b0;
      #1;
      check($sformatf("push %0h cs", d), 32'(ram_cs), 32'd1);
      check($sformatf("push %0h rws", d), 32'(ram_rws), 32'd1);
      check($sformatf("push %0h wptr", d), 32'(ram_wptr), 32'(exp_wptr));
      check($sformatf("push %0h din", d), 32'(ram_data_in), 32'(d));
   endtask

   // Pop one word; returns in the cycle pop_valid is high
   task automatic pop_word(input logic [7:0] exp_d);
      int n;
      @(negedge clk);
      pop = 1'b1;
      #1;
      n = 0;
      while (!pop_ready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      check($sformatf("pop %0h accepted", exp_d), 32'(n < 20), 32'd1);
      @(negedge clk);
      pop = 1'b0;
      #1;
      check($sformatf("pop %0h read cycle", exp_d), 32'({ram_cs, ram_rws, pop_valid}), 32'b100);
      @(negedge clk);
      #1;
      check($sformatf("pop %0h valid", exp_d), 32'(pop_valid), 32'd1);
      check($sformatf("pop %0h data", exp_d), 32'(pop_data), 32'(exp_d));
   endtask

   vec_t vt [14];
   int   ops [3];
   int   nops;

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset count", 32'(count), 32'd0);
      check("reset empty/full", 32'({empty, full}), 32'b10);
      check("reset ram ctl", 32'({ram_cs, ram_rws, ram_wptr, ram_rptr}), 32'd0);
      check("reset data", 32'({ram_data_in, pop_data, pop_valid}), 32'd0);

      // push 11,22,33 then pop until empty, including a pop on empty
      vt[0]  = mk(1, 0, 8'h11, 1,   0,   0, 0, 0, 0, 8'h00);
      vt[1]  = mk(1, 0, 8'h22, 0,   0,   1, 1, 0, 0, 8'h00);
      vt[2]  = mk(1, 0, 8'h22, 1,   !RR, 0, 0, 1, 0, 8'h00);
      vt[3]  = mk(1, 0, 8'h33, 0,   0,   1, 1, 1, 0, 8'h00);
      vt[4]  = mk(1, 0, 8'h33, 1,   !RR, 0, 0, 2, 0, 8'h00);
      vt[5]  = mk(0, 0, 8'h00, 0,   0,   1, 1, 2, 0, 8'h00);
      vt[6]  = mk(0, 1, 8'h00, RR,  1,   0, 0, 3, 0, 8'h00);
      vt[7]  = mk(0, 1, 8'h00, 0,   0,   1, 0, 3, 0, 8'h00);
      vt[8]  = mk(0, 1, 8'h00, RR,  1,   0, 0, 2, 1, 8'h11);
      vt[9]  = mk(0, 1, 8'h00, 0,   0,   1, 0, 2, 0, 8'h11);
      vt[10] = mk(0, 1, 8'h00, RR,  1,   0, 0, 1, 1, 8'h22);
      vt[11] = mk(0, 1, 8'h00, 0,   0,   1, 0, 1, 0, 8'h22);
      vt[12] = mk(0, 1, 8'h00, 1,   0,   0, 0, 0, 1, 8'h33);
      vt[13] = mk(0, 1, 8'h00, 1,   0,   0, 0, 0, 0, 8'h33);

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         push = vt[i].push; pop = vt[i].pop; push_data = vt[i].din;
         #1;
         check($sformatf("vec%0d ready", i), 32'({push_ready, pop_ready}), 32'({vt[i].pr, vt[i].qr}));
         check($sformatf("vec%0d ram", i), 32'({ram_cs, ram_rws}), 32'({vt[i].cs, vt[i].rws}));
         check($sformatf("vec%0d count", i), 32'(count), 32'(vt[i].cnt));
         check($sformatf("vec%0d flags", i), 32'({empty, full}),
               32'({vt[i].cnt == 4'd0, vt[i].cnt == 4'd8}));
         check($sformatf("vec%0d pop_valid", i), 32'(pop_valid), 32'(vt[i].pv));
         if (vt[i].pv) check($sformatf("vec%0d pop_data", i), 32'(pop_data), 32'(vt[i].pd));
      end
      push = 1'b0; pop = 1'b0;

      // fill, overflow attempt, wrap and order
      do_reset();
      for (int i = 0; i < 8; i++) push_word(8'h40 + 8'(i), 3'(i));
      @(negedge clk);
      #1;
      check("fill count", 32'(count), 32'd8);
      check("fill full/ready", 32'({full, push_ready}), 32'b10);
      push = 1'b1; push_data = 8'hAA;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("overflow%0d", i), 32'({ram_cs, push_ready, count}), 32'({2'b00, 4'd8}));
         @(negedge clk);
      end
      push = 1'b0;
      for (int i = 0; i < 4; i++) pop_word(8'h40 + 8'(i));
      for (int i = 0; i < 4; i++) push_word(8'h50 + 8'(i), 3'(i));
      for (int i = 4; i < 8; i++) pop_word(8'h40 + 8'(i));
      for (int i = 0; i < 4; i++) pop_word(8'h50 + 8'(i));
      @(negedge clk);
      #1;
      check("drain empty", 32'({empty, count}), 32'({1'b1, 4'd0}));

      // simultaneous push/pop with count=2
      do_reset();
      push_word(8'h60, 3'd0);
      push_word(8'h61, 3'd1);
      @(negedge clk);
      push = 1'b1; push_data = 8'h62; pop = 1'b1;
      nops = 0;
      for (int c = 0; c < 40 && nops < 3; c++) begin
         #1;
         if (ram_cs) begin
            ops[nops] = 32'(ram_rws);
            nops++;
         end
         if (nops < 3) @(negedge clk);
      end
      push = 1'b0; pop = 1'b0;
      check("arb op count", 32'(nops), 32'd3);
      check("arb op0", 32'(ops[0]), 32'(RR));
      check("arb op1", 32'(ops[1]), 32'd0);
      check("arb op2", 32'(ops[2]), 32'd1);
      repeat (3) @(negedge clk);
      #1;
      check("arb final count", 32'(count), RR ? 32'd3 : 32'd1);

      // reset in a WRITE cycle
      do_reset();
      @(negedge clk);
      push = 1'b1; push_data = 8'h77;
      @(negedge clk);
      push = 1'b0; rst = 1'b1;
      #1;
      check("rst-write in write", 32'({ram_cs, ram_rws}), 32'b11);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst-write after", 32'({ram_cs, pop_valid, empty, count}), 32'({3'b001, 4'd0}));

      // reset in a READ cycle
      push_word(8'h88, 3'd0);
      @(negedge clk);
      pop = 1'b1;
      @(negedge clk);
      pop = 1'b0; rst = 1'b1;
      #1;
      check("rst-read in read", 32'({ram_cs, ram_rws}), 32'b10);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst-read after", 32'({ram_cs, pop_valid, empty, count}), 32'({3'b001, 4'd0}));
      @(negedge clk);
      #1;
      check("rst-read no valid", 32'({pop_valid, ram_cs}), 32'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ff_ctrl.md
FF_CTRL -- requirements
Module: ff_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, meaning RAM address width.
REQ-003 The block SHALL have parameter DEPTH, default 1 << ADDR_WIDTH, meaning the number of entries.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have these ports:
- push  input  1  write request
- push_data  input  DATA_WIDTH  write word
- push_ready  output  1  write request accepted this cycle when high
- pop  input  1  read request
- pop_ready  output  1  read request accepted this cycle when high
- pop_data  output  DATA_WIDTH  registered read word
- pop_valid  output  1  one-cycle strobe, pop_data valid
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  ADDR_WIDTH+1  occupancy
REQ-006 The block SHALL have these RAM-side ports, all registered outputs:
- ram_cs  output  1  chip select
- ram_rws  output  1  1 = write, 0 = read
- ram_wptr  output  ADDR_WIDTH  write address
- ram_rptr  output  ADDR_WIDTH  read address
- ram_data_in  output  DATA_WIDTH  word to the RAM
- ram_data_out  input  DATA_WIDTH  word from the RAM, valid during a read cycle

Function
REQ-007 The FSM SHALL have states IDLE, WRITE and READ; WRITE and READ SHALL each last exactly one cycle and then return to IDLE.
REQ-008 push_ready SHALL be (state==IDLE && !full), and pop_ready SHALL be (state==IDLE && !empty), both combinational.
REQ-009 A push is accepted when push && push_ready at a rising edge: the next state is WRITE, and ram_cs=1, ram_rws=1, ram_wptr=wptr and ram_data_in=push_data are registered.
REQ-010 A pop is accepted when pop && pop_ready at a rising edge: the next state is READ, and ram_cs=1, ram_rws=0, ram_rptr=rptr are registered.
REQ-011 In IDLE, ram_cs SHALL be 0 and ram_rws SHALL be 0; ram_wptr, ram_rptr and ram_data_in SHALL hold their values.
REQ-012 At the end of WRITE: wptr+1 and count+1.
REQ-013 At the end of READ: pop_data<=ram_data_out, pop_valid<=1 for exactly one cycle, rptr+1 and count-1.
REQ-014 Pop latency SHALL be 2 cycles: a pop accepted at edge N produces pop_valid high in the cycle after edge N+1.
REQ-015 Pointers SHALL wrap from DEPTH-1 to 0; count SHALL never exceed DEPTH or go below 0.
REQ-016 A push while full, or a pop while empty, SHALL be ignored: no state change and no RAM access.
REQ-017 When push and pop are both requested and both ready, exactly one SHALL be accepted, as selected by REQ-021/REQ-022; the loser SHALL see ready low in that cycle and must hold its request.
REQ-018 Maximum throughput SHALL be one operation per 2 cycles.

Reset
REQ-019 When rst is high at a rising edge, the block SHALL reset to: state=IDLE, wptr=0, rptr=0, count=0, ram_cs=0, ram_rws=0, ram_wptr=0, ram_rptr=0, ram_data_in=0, pop_data=0, pop_valid=0.
REQ-020 rst SHALL take priority over any request; reset during WRITE or READ SHALL abort the access (ram_cs=0 next cycle, no pop_valid); RAM contents after such a reset are don't-care.

Configuration
REQ-021 With FF_CTRL_RR_ARB_EN defined, simultaneous push/pop SHALL use round-robin arbitration: a 1-bit last-served flag (reset to "pop") makes the side not served last win.
REQ-022 Without FF_CTRL_RR_ARB_EN, pop SHALL have fixed priority over push.

Verification
REQ-023 Reset, then push 0x11, 0x22, 0x33, then pop three times -> pop_data 0x11, 0x22, 0x33, each 2 cycles after acceptance; count goes 3 -> 0 and empty=1.
REQ-024 Push 8 words -> full=1, push_ready=0; a 9th push with push_data=0xAA is ignored, count stays 8 and ram_cs stays 0.
REQ-025 Pop with empty=1 -> pop_ready=0, ram_cs stays 0, no pop_valid.
REQ-026 Push 8, pop 4, push 4 -> ram_wptr goes 7 then 0..3; the following 8 pops return in push order.
REQ-027 With count=2, hold push and pop high together -> with FF_CTRL_RR_ARB_EN, the order is push, pop, push...; without it, pops are served until empty and then the push.
REQ-028 Assert rst in a WRITE cycle -> next cycle ram_cs=0, count=0, empty=1, pop_valid=0.
